// File: rtl/angstrom_pkg.sv
// Shared definitions for the nibble-RAM access path: RAM geometry, burst
// sequencer states and address/nibble types.
package angstrom_pkg;

  localparam int ADDR_W  = 12;
  localparam int NIB_W   = 4;
  localparam int MAX_NIB = 4;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_e;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [NIB_W-1:0]  nib_t;

endpackage

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer between the core and the 4096x4 RAM: turns one 1-4 nibble
// request into consecutive single-nibble RAM accesses and assembles read data.
module ram_burst_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int NIB_W   = 4,
  parameter int MAX_NIB = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_i,
  input  logic                         we_i,
  input  logic [$clog2(MAX_NIB)-1:0]   len_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [NIB_W*MAX_NIB-1:0]     wdata_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [NIB_W*MAX_NIB-1:0]     rdata_o,
  output logic                         ram_ren_o,
  output logic                         ram_wen_o,
  output logic [ADDR_W-1:0]            ram_addr_o,
  output logic [NIB_W-1:0]             ram_din_o,
  input  logic [NIB_W-1:0]             ram_dout_i
);
  import angstrom_pkg::*;

  localparam int DATA_W = NIB_W * MAX_NIB;
  localparam int CNT_W  = $clog2(MAX_NIB);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e              r_state;
  logic                r_we;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_shadow;

  function automatic logic [DATA_W-1:0] put_nib(input logic [DATA_W-1:0] v,
                                                input logic [CNT_W-1:0]  idx,
                                                input logic [NIB_W-1:0]  nib);
    logic [DATA_W-1:0] res;
    res = v;
    res[idx*NIB_W +: NIB_W] = nib;
    return res;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_shadow   <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      rdata_o    <= '0;
      ram_ren_o  <= 1'b0;
      ram_wen_o  <= 1'b0;
      ram_addr_o <= '0;
      ram_din_o  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // busy_o still high here means this is the done_o cycle: no accept
          busy_o <= 1'b0;
          done_o <= 1'b0;
          if (req_i && !busy_o) begin
            r_we    <= we_i;
            r_len   <= len_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_cnt   <= '0;
            if (!we_i) r_shadow <= '0;
            busy_o  <= 1'b1;
            r_state <= XFER;
          end
        end
        XFER: begin
          ram_addr_o <= r_addr + ADDR_W'(r_cnt);
          if (r_we) ram_din_o <= r_wdata[r_cnt*NIB_W +: NIB_W];
          ram_ren_o <= !r_we;
          ram_wen_o <= r_we;
          // the read in flight during the cycle ending now belongs to nibble r_cnt-1
          if (ram_ren_o) r_shadow <= put_nib(r_shadow, r_cnt - CNT_ONE, ram_dout_i);
          if (r_cnt == r_len) r_state <= DONE;
          else                r_cnt   <= r_cnt + CNT_ONE;
        end
        DONE: begin
          ram_ren_o <= 1'b0;
          ram_wen_o <= 1'b0;
          done_o    <= 1'b1;
          if (!r_we) rdata_o <= put_nib(r_shadow, r_len, ram_dout_i);
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
